// File: rtl/boot_fetch_controller.sv
// boot_fetch_controller: boot-copies bios words into memory, then fetches instructions at the PC.
// Define BOOT_CHECKSUM_EN to build the running sum of accepted boot words on boot_checksum.
module boot_fetch_controller #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BOOT_WORDS  = 16,
  parameter int MEM_LATENCY = 1,
  parameter int WORD_STEP   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  boot_valid,
  input  logic [DATA_WIDTH-1:0] boot_data,
  output logic                  boot_ready,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic                  CS,
  output logic                  WE,
  output logic                  OE,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [ADDR_WIDTH-1:0] pc_value,
  output logic                  enablePC,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  boot_done,
  output logic [DATA_WIDTH-1:0] boot_checksum
);
  localparam int CW = BOOT_WORDS > 1 ? $clog2(BOOT_WORDS) : 1;
  localparam int LW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;
  typedef enum logic [2:0] {IDLE, BOOT, FETCH_REQ, FETCH_WAIT, HOLD} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [LW-1:0]         lat_q, lat_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  valid_q, valid_d, en_q, en_d, done_q, done_d, accept;
  logic [ADDR_WIDTH-1:0] boot_addr;
  // The product is truncated to ADDR_WIDTH, so boot addresses wrap silently.
  assign boot_addr   = ADDR_WIDTH'(cnt_q) * ADDR_WIDTH'(WORD_STEP);
  assign enablePC    = en_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign boot_done   = done_q;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_d      = lat_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    en_d       = 1'b0;
    done_d     = done_q;
    accept     = 1'b0;
    boot_ready = 1'b0;
    Address    = addr_q;
    CS         = 1'b1;
    WE         = 1'b1;
    OE         = 1'b1;
    mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = BOOT;
      end
      BOOT: begin
        boot_ready = 1'b1;
        CS         = 1'b0;
        Address    = boot_addr;
        accept     = boot_valid;
        WE         = ~boot_valid;
        mem_wdata  = boot_valid ? boot_data : '0;
        cnt_d      = boot_valid ? cnt_q + 1'b1 : cnt_q;
        if (boot_valid && cnt_q == CW'(BOOT_WORDS - 1)) begin
          state_d = FETCH_REQ;
          done_d  = 1'b1;
        end
      end
      FETCH_REQ: begin
        Address = pc_value;
        CS      = 1'b0;
        OE      = 1'b0;
        addr_d  = pc_value;
        lat_d   = LW'(MEM_LATENCY - 1);
        state_d = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        CS = 1'b0;
        OE = 1'b0;
        if (lat_q == '0) begin
          instr_d = mem_rdata;
          valid_d = 1'b1;
          en_d    = 1'b1;
          state_d = HOLD;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      HOLD: begin
        valid_d = instr_ready ? 1'b0 : valid_q;
        state_d = instr_ready ? FETCH_REQ : HOLD;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
      addr_q  <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end
`ifdef BOOT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  assign sum_d         = accept ? sum_q + boot_data : sum_q;
  assign boot_checksum = sum_q;
  always_ff @(posedge clock) begin
    if (reset) sum_q <= '0;
    else sum_q <= sum_d;
  end
`else
  assign boot_checksum = '0;
`endif
endmodule

// File: tb/tb_boot_fetch_controller.sv
// tb_boot_fetch_controller: table-driven boot/fetch vectors, write scoreboard and latency-2 memory model.
module tb_boot_fetch_controller;
  logic        clock = 1'b0, reset = 1'b1;
  logic        boot_valid = 1'b0, instr_ready = 1'b0;
  logic [31:0] boot_data = '0, pc_glitch = '0, pc_q;
  logic        boot_ready, CS, WE, OE, enablePC, instr_valid, boot_done;
  logic [31:0] Address, mem_wdata, mem_rdata, pc_value, instr, boot_checksum;
  logic [31:0] mem [16];
  logic [31:0] rd0, rd1;
  int          checks = 0, failures = 0, en_cnt = 0, n;
  logic [63:0] wq[$];
  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        we;
    logic [31:0] addr;
    logic        rdy;
    logic        done;
  } row_t;
  row_t tbl[15];
`ifdef BOOT_CHECKSUM_EN
  localparam logic [31:0] EXP_SUM = 32'hAA;
`else
  localparam logic [31:0] EXP_SUM = 32'h0;
`endif

  boot_fetch_controller #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BOOT_WORDS(4), .MEM_LATENCY(2), .WORD_STEP(4)) dut (
    .clock(clock), .reset(reset), .boot_valid(boot_valid), .boot_data(boot_data), .boot_ready(boot_ready),
    .Address(Address), .CS(CS), .WE(WE), .OE(OE), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pc_value(pc_value), .enablePC(enablePC), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .boot_done(boot_done), .boot_checksum(boot_checksum)
  );

  always #5 clock = ~clock;

  initial for (int i = 0; i < 16; i++) mem[i] = '0;
  // Memory answers two edges after a read request; no request yields a poison word.
  always @(posedge clock) begin
    if (!CS && !WE) mem[Address[5:2]] <= mem_wdata;
    rd0 <= (!CS && !OE) ? mem[Address[5:2]] : 32'hBAD0_BAD0;
    rd1 <= rd0;
  end
  assign mem_rdata = rd1;

  always @(posedge clock) pc_q <= reset ? 32'h8 : (enablePC ? pc_q + 32'h4 : pc_q);
  assign pc_value = pc_q ^ pc_glitch;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    chk("we_oe_exclusive", {63'd0, !WE && !OE}, 64'd0);
    en_cnt = reset ? 0 : en_cnt + int'(enablePC);
    if (!CS && !WE) begin
      if (wq.size() == 0) chk("unexpected_write", {Address, mem_wdata}, 64'd0);
      else chk("write", {Address, mem_wdata}, wq.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      boot_valid = tbl[i].v;
      boot_data  = tbl[i].d;
      if (tbl[i].v && tbl[i].rdy) wq.push_back({tbl[i].addr, tbl[i].d});
      @(negedge clock);
      chk($sformatf("we[%0d]", i), WE, tbl[i].we);
      chk($sformatf("addr[%0d]", i), Address, tbl[i].addr);
      chk($sformatf("boot_ready[%0d]", i), boot_ready, tbl[i].rdy);
      chk($sformatf("boot_done[%0d]", i), boot_done, tbl[i].done);
      step();
    end
    boot_valid = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 32'h11, 1'b0, 32'h0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 32'h22, 1'b0, 32'h4, 1'b1, 1'b0};
    for (int i = 2; i <= 6; i++) tbl[i] = '{1'b0, 32'h0, 1'b1, 32'h8, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 32'h33, 1'b0, 32'h8, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 32'h44, 1'b0, 32'hC, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 32'h99, 1'b1, 32'h8, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 32'h11, 1'b0, 32'h0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 32'h22, 1'b0, 32'h4, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 32'hDEADBEEF, 1'b0, 32'h8, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 32'h44, 1'b0, 32'hC, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 32'h0, 1'b1, 32'h8, 1'b0, 1'b1};
    repeat (3) step();
    chk("rst_ctl", {CS, WE, OE, boot_ready, enablePC, instr_valid, boot_done}, 64'b1110000);
    chk("rst_addr", Address, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_instr", instr, 0);
    chk("rst_checksum", boot_checksum, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_ready", boot_ready, 0);
    chk("idle_cs", CS, 1);
    step();
    run_rows(0, 9);
    chk("checksum", boot_checksum, EXP_SUM);
    pc_glitch = 32'h30;
    @(negedge clock);
    chk("fw1_valid", instr_valid, 0);
    chk("fw1_addr", Address, 32'h8);
    chk("fw1_cs_oe", {CS, OE}, 0);
    step();
    @(negedge clock);
    chk("fw2_valid", instr_valid, 0);
    chk("fw2_addr", Address, 32'h8);
    step();
    pc_glitch = '0;
    @(negedge clock);
    chk("hold_instr", instr, 32'h33);
    chk("hold_valid", instr_valid, 1);
    chk("hold_en", enablePC, 1);
    chk("hold_cs_oe", {CS, OE}, 2'b11);
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clock);
      chk($sformatf("stall_instr[%0d]", i), instr, 32'h33);
      chk($sformatf("stall_valid[%0d]", i), instr_valid, 1);
      chk($sformatf("stall_en[%0d]", i), enablePC, 0);
      chk($sformatf("stall_oe[%0d]", i), OE, 1);
    end
    instr_ready = 1'b1;
    step();
    @(negedge clock);
    chk("refetch_valid", instr_valid, 0);
    chk("refetch_addr", Address, 32'hC);
    chk("refetch_oe", OE, 0);
    step();
    reset = 1'b1;
    step();
    chk("rst_fw_cs_oe", {CS, OE}, 2'b11);
    chk("rst_fw_valid", instr_valid, 0);
    chk("rst_fw_done", boot_done, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("reboot_idle_ready", boot_ready, 0);
    step();
    run_rows(10, 14);
    n = 0;
    @(negedge clock);
    while (!instr_valid && n < 8) begin
      n++;
      @(negedge clock);
    end
    chk("latency", n, 2);
    chk("t4_instr", instr, 32'hDEADBEEF);
    chk("t4_en", enablePC, 1);
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (n == 1) chk("t4_next_addr", Address, 32'hC);
    end while (!instr_valid && n < 10);
    chk("throughput", n, 4);
    chk("t4_instr2", instr, 32'h44);
    @(posedge clock);
    #1;
    chk("en_pulses", en_cnt, 2);
    chk("writes_drained", wq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
